// File: rtl/fftc4_collect.sv
// rtl/fftc4_collect.sv - fftc4 slot collector: rebuilds a 32-word frame from four 8-lane beats
//
// Purpose:
//   Captures one LANES-wide beat per mac_sel slot, scatters its lanes into the
//   frame word positions, and hands the finished frame downstream over a
//   valid/ready handshake. Out-of-sequence beats raise a sticky error flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   slot_valid   beat present
//   slot_sel     slot index of the beat
//   slot_data    LANES*WORD beat, lane L at [WORD*L +: WORD]
//   slot_ready   beat can be accepted (low while a finished frame waits)
//   frame_data   N*WORD frame, word k at [WORD*k +: WORD]
//   frame_valid  frame_data holds a complete frame
//   frame_ready  downstream accepts the frame
//   err_clr      synchronous clear of err_order
//   err_order    sticky out-of-sequence flag
//   frame_cnt    frames delivered, wrapping
module fftc4_collect #(
   parameter int WORD  = 64,
   parameter int LANES = 8,
   parameter int SLOTS = 4,
   parameter int CNTW  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           slot_valid,
   input  logic [1:0]                     slot_sel,
   input  logic [LANES*WORD-1:0]          slot_data,
   output logic                           slot_ready,
   output logic [LANES*SLOTS*WORD-1:0]    frame_data,
   output logic                           frame_valid,
   input  logic                           frame_ready,
   input  logic                           err_clr,
   output logic                           err_order,
   output logic [CNTW-1:0]                frame_cnt
);

   localparam int N    = LANES * SLOTS;
   localparam int HALF = LANES / 2;
   localparam int NW   = N * WORD;
   localparam logic [1:0] LAST_SLOT = 2'(SLOTS - 1);

   logic [NW-1:0] asm_buf;
   logic [NW-1:0] merged;
   logic [1:0]    exp_slot;
   logic          full_pend;

   logic accept, in_order, resync, store, complete, out_free;
   logic load_direct, load_pend, err_set;

   // Assembly buffer with the incoming beat's lanes dropped into place.
   // Out1 lanes fill the lower half of the frame, out2 lanes the upper half.
   always_comb begin
      merged = asm_buf;
      for (int m = 0; m < HALF; m++) begin
         merged[(SLOTS*m + int'(slot_sel))*WORD +: WORD] =
            slot_data[m*WORD +: WORD];
         merged[(N/2 + SLOTS*m + int'(slot_sel))*WORD +: WORD] =
            slot_data[(HALF+m)*WORD +: WORD];
      end
   end

   assign slot_ready  = !full_pend;
   assign accept      = slot_valid && slot_ready;
   assign in_order    = (slot_sel == exp_slot);
   assign resync      = !in_order && (slot_sel == 2'd0);
   assign store       = accept && (in_order || resync);
   assign complete    = accept && in_order && (slot_sel == LAST_SLOT);
   assign out_free    = !frame_valid || frame_ready;
   // full_pend blocks accepts, so these two loads never coincide.
   assign load_direct = complete && out_free;
   assign load_pend   = full_pend && out_free;
   assign err_set     = accept && !in_order;

   // A resync needs no buffer clear: every word of the discarded partial
   // frame is rewritten by in-order beats before the frame can complete.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         asm_buf     <= '0;
         exp_slot    <= 2'd0;
         full_pend   <= 1'b0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         err_order   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         if (store)
            asm_buf <= merged;

         if (accept && in_order)
            exp_slot <= (slot_sel == LAST_SLOT) ? 2'd0 : exp_slot + 2'd1;
         else if (accept && resync)
            exp_slot <= 2'd1;

         if (load_pend)
            full_pend <= 1'b0;
         else if (complete && !out_free)
            full_pend <= 1'b1;

         if (load_direct)
            frame_data <= merged;
         else if (load_pend)
            frame_data <= asm_buf;

         if (load_direct || load_pend)
            frame_valid <= 1'b1;
         else if (frame_ready)
            frame_valid <= 1'b0;

         if (frame_valid && frame_ready)
            frame_cnt <= frame_cnt + CNTW'(1);

         // Set has priority over clear.
         if (err_set)
            err_order <= 1'b1;
         else if (err_clr)
            err_order <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fftc4_collect.sv
// tb/tb_fftc4_collect.sv - scoreboard testbench for fftc4_collect
module tb_fftc4_collect;

   localparam int WORD  = 64;
   localparam int LANES = 8;
   localparam int SLOTS = 4;
   localparam int CNTW  = 8;
   localparam int N     = LANES * SLOTS;
   localparam int NW    = N * WORD;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  slot_valid;
   logic [1:0]            slot_sel;
   logic [LANES*WORD-1:0] slot_data;
   logic                  slot_ready;
   logic [NW-1:0]         frame_data;
   logic                  frame_valid;
   logic                  frame_ready;
   logic                  err_clr;
   logic                  err_order;
   logic [CNTW-1:0]       frame_cnt;

   always #5 clk = ~clk;

   fftc4_collect #(.WORD(WORD), .LANES(LANES), .SLOTS(SLOTS), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset),
      .slot_valid(slot_valid), .slot_sel(slot_sel), .slot_data(slot_data),
      .slot_ready(slot_ready),
      .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .err_clr(err_clr), .err_order(err_order), .frame_cnt(frame_cnt)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Lane L of slot s carries s<<4|L in the low byte and a tag in the top bits.
   function automatic logic [63:0] lane_val(input logic [15:0] tag, input logic [1:0] s, input int l);
      logic [7:0] b;
      b = {2'b00, s, 1'b0, 3'(l)};
      return {tag, 40'h0, b};
   endfunction

   // Reference model of the sequence rules.
   logic [NW-1:0] m_buf;
   logic [1:0]    m_exp;
   logic          m_err;
   int            exp_cnt;
   logic [NW-1:0] sb_q[$];

   task automatic model_reset();
      m_buf   = '0;
      m_exp   = 2'd0;
      m_err   = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic model_store(input logic [1:0] s, input logic [15:0] tag);
      for (int m = 0; m < 4; m++) begin
         m_buf[(4*m + int'(s))*WORD +: WORD]      = lane_val(tag, s, m);
         m_buf[(16 + 4*m + int'(s))*WORD +: WORD] = lane_val(tag, s, 4 + m);
      end
   endtask

   task automatic model_accept(input logic [1:0] s, input logic [15:0] tag);
      if (s == m_exp) begin
         model_store(s, tag);
         if (s == 2'd3) begin
            sb_q.push_back(m_buf);
            exp_cnt++;
            m_exp = 2'd0;
         end else begin
            m_exp = m_exp + 2'd1;
         end
      end else if (s == 2'd0) begin
         model_store(s, tag);
         m_exp = 2'd1;
         m_err = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   // Drive one beat; returns at posedge+1 after it is accepted.
   task automatic send_beat(input logic [1:0] s, input logic [15:0] tag);
      int n;
      slot_valid = 1'b1;
      slot_sel   = s;
      for (int l = 0; l < LANES; l++)
         slot_data[l*WORD +: WORD] = lane_val(tag, s, l);
      n = 0;
      @(negedge clk);
      while (!slot_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("beat_accept_timeout", {63'b0, slot_ready}, 64'd1);
      @(posedge clk);
      if (slot_ready)
         model_accept(s, tag);
      #1;
      slot_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] tag);
      for (int s = 0; s < 4; s++)
         send_beat(2'(s), tag);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every handshake and checks that
   // a stalled frame does not change.
   logic [NW-1:0] held;
   logic          hold_prev = 1'b0;
   logic [NW-1:0] exp_frame;

   always @(negedge clk) begin
      if (!reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check_eq("hold_w0",  frame_data[63:0],      held[63:0]);
            check_eq("hold_w31", frame_data[NW-1 -: 64], held[NW-1 -: 64]);
         end
         if (frame_valid && frame_ready) begin
            check_eq("sb_has_frame", {63'b0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
               exp_frame = sb_q.pop_front();
               for (int k = 0; k < N; k++)
                  check_eq($sformatf("frame_w%0d", k), frame_data[k*WORD +: WORD],
                           exp_frame[k*WORD +: WORD]);
            end
         end
         hold_prev = frame_valid && !frame_ready;
         held      = frame_data;
      end
   end

   initial begin
      model_reset();
      reset       = 1'b0;
      slot_valid  = 1'b0;
      slot_sel    = 2'd0;
      slot_data   = '0;
      frame_ready = 1'b0;
      err_clr     = 1'b0;

      // Reset with random inputs.
      repeat (5) begin
         @(posedge clk);
         #1;
         slot_valid  = 1'($urandom);
         slot_sel    = 2'($urandom);
         for (int l = 0; l < LANES*2; l++)
            slot_data[l*32 +: 32] = $urandom;
         frame_ready = 1'($urandom);
         err_clr     = 1'($urandom);
      end
      check_eq("rst_frame_valid", {63'b0, frame_valid}, 64'd0);
      check_eq("rst_frame_data",  {63'b0, |frame_data}, 64'd0);
      check_eq("rst_err_order",   {63'b0, err_order},   64'd0);
      check_eq("rst_frame_cnt",   64'(frame_cnt),       64'd0);
      check_eq("rst_slot_ready",  {63'b0, slot_ready},  64'd1);
      slot_valid  = 1'b0;
      frame_ready = 1'b1;
      err_clr     = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

      // In-order frame, one-cycle latency.
      send_frame(16'h0000);
      check_eq("inorder_valid", {63'b0, frame_valid}, 64'd1);
      check_eq("inorder_w21", frame_data[21*WORD +: WORD], 64'h15);
      check_eq("inorder_w0",  frame_data[0 +: WORD],       64'h00);
      check_eq("inorder_w31", frame_data[31*WORD +: WORD], 64'h37);
      idle(2);
      check_eq("inorder_cnt", 64'(frame_cnt), 64'd1);
      check_eq("inorder_drained", {63'b0, frame_valid}, 64'd0);

      // Two frames under backpressure.
      frame_ready = 1'b0;
      send_frame(16'h0001);
      send_frame(16'h0002);
      check_eq("bp_slot_ready", {63'b0, slot_ready}, 64'd0);
      check_eq("bp_a_held", frame_data[0 +: WORD], lane_val(16'h0001, 2'd0, 0));
      slot_valid = 1'b1;
      slot_sel   = 2'd0;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_stall", {63'b0, slot_ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      slot_valid  = 1'b0;
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_b_valid", {63'b0, frame_valid}, 64'd1);
      check_eq("bp_b_w0", frame_data[0 +: WORD], lane_val(16'h0002, 2'd0, 0));
      check_eq("bp_ready_back", {63'b0, slot_ready}, 64'd1);
      idle(2);
      check_eq("bp_cnt", 64'(frame_cnt), 64'd3);

      // Out-of-order slot 3 is dropped; frame completes with original 0,1.
      send_beat(2'd0, 16'h0003);
      send_beat(2'd1, 16'h0003);
      send_beat(2'd3, 16'h0003);
      check_eq("ooo_err", {63'b0, err_order}, {63'b0, m_err});
      send_beat(2'd2, 16'h0006);
      send_beat(2'd3, 16'h0006);
      check_eq("ooo_w0", frame_data[0 +: WORD], lane_val(16'h0003, 2'd0, 0));
      check_eq("ooo_w3", frame_data[3*WORD +: WORD], lane_val(16'h0006, 2'd3, 0));
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      m_err   = 1'b0;
      check_eq("errclr", {63'b0, err_order}, 64'd0);
      // Set wins over a simultaneous clear.
      err_clr = 1'b1;
      send_beat(2'd2, 16'h0007);
      err_clr = 1'b0;
      check_eq("err_set_wins", {63'b0, err_order}, 64'd1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      m_err   = 1'b0;
      idle(2);
      check_eq("ooo_cnt", 64'(frame_cnt), 64'd4);

      // Resync on an early slot 0.
      send_beat(2'd0, 16'h0004);
      send_beat(2'd1, 16'h0004);
      send_frame(16'h0005);
      check_eq("resync_err", {63'b0, err_order}, 64'd1);
      check_eq("resync_w1", frame_data[1*WORD +: WORD], lane_val(16'h0005, 2'd1, 0));
      check_eq("resync_w16", frame_data[16*WORD +: WORD], lane_val(16'h0005, 2'd0, 4));
      idle(2);

      // Run the delivered-frame count around its wrap.
      while (exp_cnt < 256)
         send_frame(16'(exp_cnt + 16'h0100));
      idle(3);
      check_eq("wrap_cnt", 64'(frame_cnt), 64'(CNTW'(exp_cnt)));

      // Reset after slot 2 of a partial frame.
      send_beat(2'd0, 16'h0008);
      send_beat(2'd1, 16'h0008);
      send_beat(2'd2, 16'h0008);
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("midrst_valid", {63'b0, frame_valid}, 64'd0);
      check_eq("midrst_cnt",   64'(frame_cnt),       64'd0);
      check_eq("midrst_err",   {63'b0, err_order},   64'd0);
      check_eq("midrst_ready", {63'b0, slot_ready},  64'd1);
      idle(2);
      reset = 1'b1;
      idle(1);
      send_beat(2'd3, 16'h0009);
      check_eq("midrst_need_slot0", {63'b0, err_order}, 64'd1);
      check_eq("midrst_no_frame", {63'b0, frame_valid}, 64'd0);
      send_frame(16'h000a);
      idle(3);
      check_eq("final_cnt", 64'(frame_cnt), 64'd1);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fftc4_collect.md
Name: fftc4_collect

Overview:
- Receiving end of the fftc4 slot protocol. fftc4 drives four MAC units time-multiplexed over mac_sel slots 0..3, and each MAC produces two 64-bit complex results per slot.
- This block captures one 8-lane beat per slot, tagged with its slot number, and rebuilds the full 32-word twiddled frame in registers.
- It presents the frame as a 2048-bit word with a valid/ready handshake to the next butterfly stage.
- It replaces the latch-based output demux with clocked, handshaked storage.

Parameters:
- WORD, 64, complex word width: {real fp32 [63:32], imag fp32 [31:0]}. Carried opaquely; no arithmetic.
- LANES, 8, words per beat: 4 MACs x 2 outputs.
- SLOTS, 4, beats per frame. N = LANES*SLOTS = 32 words.
- CNTW, 8, width of frame_cnt.

Ports:
- clk, input, 1, clock; all flops on the rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- slot_valid, input, 1, a beat is present.
- slot_sel, input, 2, slot index of the beat (mac_sel value).
- slot_data, input, LANES*WORD, lane L at bits [64L+63:64L]. Lanes 0-3 = mac1..mac4 out1; lanes 4-7 = mac1..mac4 out2.
- slot_ready, output, 1, block can accept a beat.
- frame_data, output, N*WORD, word k at bits [64k+63:64k].
- frame_valid, output, 1, frame_data holds a complete frame.
- frame_ready, input, 1, downstream accepts the frame.
- err_clr, input, 1, synchronous clear of err_order.
- err_order, output, 1, sticky out-of-sequence flag.
- frame_cnt, output, CNTW, count of frames delivered.

Behaviour:
- Reset (reset=0, asynchronous) clears: frame_data, frame_valid, err_order, frame_cnt, the assembly buffer, exp_slot (expected slot), full_pend. slot_ready is combinational !full_pend, so it reads 1 out of reset.
- Accept = slot_valid && slot_ready.
- Word mapping for an accepted beat with slot s, for m = 0..3:
  - lane m -> word 4m+s.
  - lane 4+m -> word 16+4m+s.
- Sequence rules, checked on each accept:
  - slot_sel == exp_slot: beat is stored; exp_slot increments, wrapping 3->0.
  - slot_sel != exp_slot and slot_sel == 0: partial frame is discarded; beat is stored as slot 0; exp_slot = 1; err_order set.
  - Otherwise: beat is dropped; err_order set; exp_slot unchanged.
- Completion happens on accepting slot 3 (in order):
  - If the output is free (!frame_valid || frame_ready): frame_data loads {buffered slots 0-2, incoming slot 3} at that edge. frame_valid = 1 the next cycle, giving 1-cycle latency from the slot-3 accept.
  - Otherwise: full_pend = 1 and slot_ready drops. When the output frees, the buffer moves to frame_data and full_pend clears at that edge.
- While full_pend = 1, no beats are accepted.
- Throughput: one frame per 4 cycles when frame_ready is held at 1.
- Output handshake:
  - frame_valid && frame_ready consumes the frame. frame_valid clears unless a new frame loads in the same edge, in which case it stays 1.
  - frame_data is stable while frame_valid && !frame_ready.
  - frame_cnt increments on each handshake and wraps from 2^CNTW-1 to 0.
- Error flag priority: if err_clr and a new error occur in the same cycle, the set wins. err_order has no effect on data flow.
- Reset mid-fill or while a frame is held discards everything; the block restarts expecting slot 0.

Test Plan:
- Reset: hold reset=0 with random inputs -> frame_valid=0, frame_data=0, err_order=0, frame_cnt=0, slot_ready=1. Release reset; first frame aligns to slot 0.
- In-order frame: 4 beats with slot_sel 0,1,2,3 on consecutive cycles, lane L of slot s = 64'h(s<<4|L), frame_ready=1.
  - frame_valid=1 one cycle after the slot-3 beat.
  - word 4m+s = s<<4|m and word 16+4m+s = s<<4|(4+m); e.g. word 21 = 64'h15.
  - frame_cnt=1 after the handshake.
- Back-to-back with backpressure: frame_ready=0, send 2 frames.
  - Frame A is held stable.
  - After frame B's slot 3: slot_ready=0 and further beats stall.
  - Raise frame_ready: A is consumed; B appears the next cycle; slot_ready=1; frame_cnt=2.
- Out-of-order: slots 0,1,3 -> slot-3 beat dropped, err_order=1. Then slots 2,3 -> frame completes with the original slots 0,1. err_clr clears err_order.
- Resync: slots 0,1 then 0,1,2,3 -> err_order=1; output frame contains only the second set of beats.
- Wrap and mid-op reset: 256 frames -> frame_cnt wraps to 0. Assert reset after slot 2 -> frame_valid=0 and the next frame requires slot 0.
